// File: rtl/mem_wb_skid.sv
// MEM/WB pipeline stage: valid/ready handshake with a head + skid register pair.
// Optional operand forwarding from the head entry when MEM_WB_FWD_EN is defined.
module mem_wb_skid #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              reloj,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] DO_MEM,
  input  logic [ADDR_W-1:0] DIR_MEM,
  input  logic [RD_W-1:0]   rd,
  input  logic              wb_en,
  input  logic              mem_to_reg,
`ifdef MEM_WB_FWD_EN
  input  logic [RD_W-1:0]   rs1,
  input  logic [RD_W-1:0]   rs2,
  output logic              fwd_rs1,
  output logic              fwd_rs2,
  output logic [((DATA_W > ADDR_W) ? DATA_W : ADDR_W)-1:0] fwd_data,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] DO_MEMo,
  output logic [ADDR_W-1:0] DIR_MEMo,
  output logic [RD_W-1:0]   rd_o,
  output logic              wb_en_o,
  output logic              mem_to_reg_o
);

  localparam int PW = DATA_W + ADDR_W + RD_W + 2;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]    state_r;
  logic [1:0]    state_nxt_s;
  logic          out_valid_r;
  logic          in_ready_r;
  logic [PW-1:0] head_r;
  logic [PW-1:0] skid_r;
  logic [PW-1:0] in_pl_s;
  logic          accept_s;
  logic          pop_s;
  logic          head_ld_s;
  logic          head_from_skid_s;
  logic          skid_ld_s;

  // Register 0 is hardwired, so its writes are squashed at capture time.
  assign in_pl_s  = {DO_MEM, DIR_MEM, rd, wb_en & (rd != {RD_W{1'b0}}), mem_to_reg};
  assign accept_s = in_valid & in_ready_r;
  assign pop_s    = out_valid_r & out_ready;

  // Next-state and register-load decode for the head/skid pair.
  always_comb begin
    state_nxt_s      = state_r;
    head_ld_s        = 1'b0;
    head_from_skid_s = 1'b0;
    skid_ld_s        = 1'b0;
    case (state_r)
      ST_EMPTY: begin
        if (accept_s) begin
          state_nxt_s = ST_ONE;
          head_ld_s   = 1'b1;
        end else begin
          state_nxt_s = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (accept_s && !pop_s) begin
          state_nxt_s = ST_FULL;
          skid_ld_s   = 1'b1;
        end else if (accept_s && pop_s) begin
          state_nxt_s = ST_ONE;
          head_ld_s   = 1'b1;
        end else if (pop_s) begin
          state_nxt_s = ST_EMPTY;
        end else begin
          state_nxt_s = ST_ONE;
        end
      end
      ST_FULL: begin
        if (pop_s) begin
          state_nxt_s      = ST_ONE;
          head_ld_s        = 1'b1;
          head_from_skid_s = 1'b1;
        end else begin
          state_nxt_s = ST_FULL;
        end
      end
      default: begin
        state_nxt_s = ST_EMPTY;
      end
    endcase
  end

  // Control state; valid/ready are registered copies derived from the next state.
  always_ff @(posedge reloj or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_EMPTY;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else if (flush) begin
      state_r     <= ST_EMPTY;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      state_r     <= state_nxt_s;
      out_valid_r <= (state_nxt_s != ST_EMPTY);
      in_ready_r  <= (state_nxt_s != ST_FULL);
    end
  end

  // Payload storage; registers hold unless loaded, and flush clears them.
  always_ff @(posedge reloj or negedge reset_n) begin
    if (!reset_n) begin
      head_r <= {PW{1'b0}};
      skid_r <= {PW{1'b0}};
    end else if (flush) begin
      head_r <= {PW{1'b0}};
      skid_r <= {PW{1'b0}};
    end else begin
      if (head_ld_s) begin
        head_r <= head_from_skid_s ? skid_r : in_pl_s;
      end
      if (skid_ld_s) begin
        skid_r <= in_pl_s;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign {DO_MEMo, DIR_MEMo, rd_o, wb_en_o, mem_to_reg_o} = head_r;

`ifdef MEM_WB_FWD_EN
  localparam int FWD_W = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;

  assign fwd_rs1  = out_valid_r & wb_en_o & (rd_o == rs1);
  assign fwd_rs2  = out_valid_r & wb_en_o & (rd_o == rs2);
  assign fwd_data = mem_to_reg_o ? FWD_W'(DO_MEMo) : FWD_W'(DIR_MEMo);
`endif

endmodule
